cic_tdm_deframer: RTL and testbench

- Sits directly downstream of the 16-channel CIC decimator.
- Consumes its time-division-multiplexed Avalon-ST output stream: data, channel, start/end of packet, error, valid/ready.
- Reassembles each packet of NUM_CH channel samples into one parallel frame and presents it on a valid/ready interface for the downstream adaptive-filter datapath.
- Checks channel sequencing and packet framing, drops malformed frames and counts them.

---
 rtl/cic_tdm_deframer.sv | 138 +++++++++++++
 tb/tb_cic_tdm_deframer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_tdm_deframer.sv
// Reassembles the CIC decimator's TDM Avalon-ST stream into parallel NUM_CH-sample frames.
// Optional: define CIC_DEFRAMER_ERRDROP_EN to drop (and count) frames carrying beat errors.
module cic_tdm_deframer #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 16,
  parameter int CH_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [CH_W-1:0]          in_channel,
  input  logic [1:0]               in_error,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [1:0]               out_error,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         frame_err_cnt,
  output logic                     sync_lost
);

  typedef enum logic {HUNT, COLLECT} state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t                    state, state_next;
  logic [DATA_W-1:0]         col_buf [NUM_CH];
  logic [CH_W-1:0]           exp_ch;
  logic [1:0]                acc_err;
  logic [NUM_CH*DATA_W-1:0]  frame_next;
  logic [1:0]                done_err;

  logic accept, is_start, at_last, good_beat, hunt_start, hunt_single;
  logic frame_done, bad_beat, restart, drop, load, cnt_inc;

  assign accept      = in_valid && in_ready;
  assign is_start    = in_startofpacket && (in_channel == '0);
  assign at_last     = (state == COLLECT) && (exp_ch == LAST_CH);
  assign good_beat   = (state == COLLECT) && (in_channel == exp_ch) && !in_startofpacket &&
                       (in_endofpacket == (exp_ch == LAST_CH));
  // A single-channel frame completes on its start beat, straight out of HUNT.
  assign hunt_start  = (state == HUNT) && is_start && (NUM_CH > 1);
  assign hunt_single = (state == HUNT) && is_start && in_endofpacket && (NUM_CH == 1);
  assign frame_done  = accept && ((good_beat && at_last) || hunt_single);
  assign bad_beat    = accept && (state == COLLECT) && !good_beat;
  assign restart     = bad_beat && is_start;
  assign done_err    = (state == HUNT) ? in_error : (acc_err | in_error);

`ifdef CIC_DEFRAMER_ERRDROP_EN
  assign drop = frame_done && (done_err != 2'b00);
`else
  assign drop = 1'b0;
`endif
  assign load    = frame_done && !drop;
  assign cnt_inc = bad_beat || drop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    frame_next = '0;
    for (int k = 0; k < NUM_CH; k++) frame_next[k*DATA_W +: DATA_W] = col_buf[k];
    frame_next[(NUM_CH-1)*DATA_W +: DATA_W] = in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT:    if (accept && hunt_start) state_next = COLLECT;
      COLLECT: if (accept) begin
                 if (good_beat) state_next = at_last ? HUNT : COLLECT;
                 else           state_next = restart ? COLLECT : HUNT;
               end
      default: state_next = HUNT;
    endcase
  end

  // Only the beat that would complete a frame must wait for the output slot.
  always_comb begin
    in_ready = 1'b1;
    if ((at_last || ((state == HUNT) && (NUM_CH == 1))) && out_valid && !out_ready)
      in_ready = 1'b0;
  end

  // NOTE: the collect buffer is a small flop array, so it is reset along with the rest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) col_buf[k] <= '0;
      exp_ch        <= '0;
      acc_err       <= '0;
      sync_lost     <= 1'b1;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_error     <= '0;
      frame_err_cnt <= '0;
    end else begin
      if (accept) begin
        if (hunt_start || restart) begin
          col_buf[0] <= in_data;
          exp_ch     <= CH_W'(1);
          acc_err    <= in_error;
          sync_lost  <= 1'b0;
        end else if (hunt_single) begin
          sync_lost <= 1'b0;
        end else if (good_beat) begin
          col_buf[exp_ch] <= in_data;
          acc_err         <= acc_err | in_error;
          exp_ch          <= at_last ? '0 : exp_ch + CH_W'(1);
        end else if (bad_beat) begin
          exp_ch    <= '0;
          acc_err   <= '0;
          sync_lost <= 1'b1;
        end
      end

      // A new frame wins over clearing the slot on a same-cycle transfer.
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= frame_next;
        out_error <= done_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (cnt_inc && (frame_err_cnt != '1))
        frame_err_cnt <= frame_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cic_tdm_deframer.sv
// Self-checking bench for cic_tdm_deframer: directed scenarios, a vector table and
// randomized traffic compared every cycle against a queue-based frame model.
module tb_cic_tdm_deframer;

  localparam int NUM_CH = 16;
  localparam int DATA_W = 16;
  localparam int CH_W   = 4;
  localparam int CNT_W  = 4;
  localparam int FW     = NUM_CH * DATA_W;

  logic              clk, reset;
  logic [DATA_W-1:0] in_data;
  logic [CH_W-1:0]   in_channel;
  logic [1:0]        in_error;
  logic              in_startofpacket, in_endofpacket, in_valid, in_ready;
  logic [FW-1:0]     out_data;
  logic [1:0]        out_error;
  logic              out_valid, out_ready;
  logic [CNT_W-1:0]  frame_err_cnt;
  logic              sync_lost;

  cic_tdm_deframer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_channel(in_channel), .in_error(in_error),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_error(out_error), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err_cnt(frame_err_cnt), .sync_lost(sync_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of samples collected so far (empty = hunting) plus a one-frame output slot.
  int            m_q[$];
  logic [1:0]    m_acc, m_err;
  logic          m_sync, m_valid, m_accepted;
  logic [FW-1:0] m_data;
  int            m_cnt;
  int            bp_cycles = 0;

  function automatic logic model_ready();
    return !((m_q.size() == NUM_CH - 1) && m_valid && !out_ready);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_acc = 2'b00; m_err = 2'b00; m_sync = 1'b1; m_valid = 1'b0;
    m_data = '0; m_cnt = 0; m_accepted = 1'b0;
  endtask

  task automatic model_step();
    logic acc, xfer, load, inc, start;
    logic [FW-1:0] f;
    int pos;
    f = '0; load = 1'b0; inc = 1'b0;
    acc   = in_valid && model_ready();
    xfer  = m_valid && out_ready;
    start = in_startofpacket && (in_channel == 0);
    m_accepted = acc;
    if (acc) begin
      if (m_q.size() == 0) begin
        if (start) begin
          m_q.push_back(int'(in_data)); m_acc = in_error; m_sync = 1'b0;
        end
      end else begin
        pos = m_q.size();
        if (int'(in_channel) == pos && !in_startofpacket && (in_endofpacket == (pos == NUM_CH - 1))) begin
          m_q.push_back(int'(in_data));
          m_acc = m_acc | in_error;
          if (m_q.size() == NUM_CH) begin
            for (int k = 0; k < NUM_CH; k++) f[k*DATA_W +: DATA_W] = DATA_W'(m_q[k]);
            m_q.delete();
`ifdef CIC_DEFRAMER_ERRDROP_EN
            if (m_acc != 2'b00) inc = 1'b1;
            else                load = 1'b1;
`else
            load = 1'b1;
`endif
          end
        end else begin
          inc = 1'b1; m_sync = 1'b1; m_q.delete();
          if (start) begin
            m_q.push_back(int'(in_data)); m_acc = in_error; m_sync = 1'b0;
          end
        end
      end
    end
    if (load) begin
      m_valid = 1'b1; m_data = f; m_err = m_acc;
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (inc && m_cnt < (1 << CNT_W) - 1) m_cnt++;
  endtask

  task automatic compare_all();
    check("in_ready",  in_ready,      model_ready());
    check("out_valid", out_valid,     m_valid);
    check("out_data",  out_data,      m_data);
    check("out_error", out_error,     m_err);
    check("err_cnt",   frame_err_cnt, m_cnt);
    check("sync_lost", sync_lost,     m_sync);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    compare_all();
    if (bp_cycles > 0) begin
      bp_cycles--;
      if (bp_cycles == 0) out_ready = 1'b1;
    end
    #1;
  endtask

  task automatic send_beat(input int ch, input logic sop, input logic eop,
                           input logic [1:0] err, input logic [DATA_W-1:0] data);
    int n;
    in_channel = CH_W'(ch); in_startofpacket = sop; in_endofpacket = eop;
    in_error = err; in_data = data; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!in_ready) check("ready_timeout", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [DATA_W-1:0] base, input int skip_ch,
                             input int err_ch, input logic [1:0] err_val);
    for (int ch = 0; ch < NUM_CH; ch++)
      if (ch != skip_ch)
        send_beat(ch, ch == 0, ch == NUM_CH - 1, (ch == err_ch) ? err_val : 2'b00,
                  base + DATA_W'(ch));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [FW-1:0] ramp_frame(input logic [DATA_W-1:0] base);
    logic [FW-1:0] f;
    for (int k = 0; k < NUM_CH; k++) f[k*DATA_W +: DATA_W] = base + DATA_W'(k);
    return f;
  endfunction

  typedef struct {
    int         ch;
    logic       sop;
    logic       eop;
    logic       exp_sync;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int g_pos;
    int r;
    int ch;
    logic sop, eop;

    // Framing corner cases, applied from a fresh HUNT state; expectations hold after each beat.
    vecs[0] = '{0, 1'b1, 1'b0, 1'b0, 4'd0};  // start
    vecs[1] = '{1, 1'b0, 1'b0, 1'b0, 4'd0};  // good
    vecs[2] = '{5, 1'b0, 1'b0, 1'b1, 4'd1};  // wrong channel
    vecs[3] = '{1, 1'b0, 1'b0, 1'b1, 4'd1};  // ignored while hunting
    vecs[4] = '{0, 1'b1, 1'b0, 1'b0, 4'd1};  // start
    vecs[5] = '{1, 1'b1, 1'b0, 1'b1, 4'd2};  // sop at non-zero position
    vecs[6] = '{0, 1'b1, 1'b0, 1'b0, 4'd2};  // start
    vecs[7] = '{0, 1'b1, 1'b0, 1'b0, 4'd3};  // bad but restarts collection
    vecs[8] = '{1, 1'b0, 1'b1, 1'b1, 4'd4};  // early eop

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_channel = '0; in_error = '0;
    in_startofpacket = 1'b0; in_endofpacket = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("rst_sync_lost", sync_lost, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_cnt", frame_err_cnt, 0);
    reset = 1'b0;
    #1;

    // Three back-to-back good packets.
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        send_beat(c, c == 0, c == NUM_CH - 1, 2'b00, 16'h0100 + DATA_W'(c));
        if (c == 0) check("sync_after_sop", sync_lost, 1'b0);
        if (c == 0 && p > 0) check("valid_one_cycle", out_valid, 1'b0);
      end
      check("good_valid", out_valid, 1'b1);
      check("good_data", out_data, ramp_frame(16'h0100));
      check("good_cnt", frame_err_cnt, 0);
    end
    tick();

    // Missing channel 7, then a clean packet.
    send_packet(16'h0200, 7, -1, 2'b00);
    check("miss_cnt", frame_err_cnt, 1);
    check("miss_sync", sync_lost, 1'b1);
    check("miss_valid", out_valid, 1'b0);
    send_packet(16'h0300, -1, -1, 2'b00);
    check("recover_data", out_data, ramp_frame(16'h0300));
    check("recover_sync", sync_lost, 1'b0);
    tick();

    // Downstream stall for 40 cycles while two packets stream.
    out_ready = 1'b0;
    bp_cycles = 40;
    send_packet(16'h0A00, -1, -1, 2'b00);
    for (int c = 0; c < NUM_CH - 1; c++) send_beat(c, c == 0, 1'b0, 2'b00, 16'h0B00 + DATA_W'(c));
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_hold_valid", out_valid, 1'b1);
    check("bp_hold_data", out_data, ramp_frame(16'h0A00));
    send_beat(NUM_CH - 1, 1'b0, 1'b1, 2'b00, 16'h0B00 + DATA_W'(NUM_CH - 1));
    check("bp_second_valid", out_valid, 1'b1);
    check("bp_second_data", out_data, ramp_frame(16'h0B00));
    tick();
    check("bp_drained", out_valid, 1'b0);

    // Error flag on channel 3 only.
    send_packet(16'h0400, -1, 3, 2'b01);
`ifdef CIC_DEFRAMER_ERRDROP_EN
    check("errdrop_valid", out_valid, 1'b0);
    check("errdrop_cnt", frame_err_cnt, 2);
`else
    check("err_valid", out_valid, 1'b1);
    check("err_flags", out_error, 2'b01);
    check("err_cnt", frame_err_cnt, 1);
`endif
    tick();

    // Reset asserted with channel 9 on the bus.
    for (int c = 0; c < 9; c++) send_beat(c, c == 0, 1'b0, 2'b00, 16'h0500 + DATA_W'(c));
    in_channel = 4'd9; in_data = 16'h0509; in_valid = 1'b1;
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_sync", sync_lost, 1'b1);
    check("mid_rst_cnt", frame_err_cnt, 0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int c = 10; c < NUM_CH; c++) send_beat(c, 1'b0, c == NUM_CH - 1, 2'b00, 16'h0500 + DATA_W'(c));
    check("tail_valid", out_valid, 1'b0);
    check("tail_sync", sync_lost, 1'b1);
    check("tail_cnt", frame_err_cnt, 0);

    // Vector table.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_beat(vecs[i].ch, vecs[i].sop, vecs[i].eop, 2'b00, 16'h0600 + DATA_W'(i));
      check($sformatf("vec%0d_sync", i), sync_lost, vecs[i].exp_sync);
      check($sformatf("vec%0d_cnt", i), frame_err_cnt, vecs[i].exp_cnt);
    end

    // Counter saturation with 2^CNT_W+3 malformed packets.
    do_reset();
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      send_beat(0, 1'b1, 1'b0, 2'b00, 16'h0700);
      send_beat(2, 1'b0, 1'b0, 2'b00, 16'h0702);
    end
    check("sat_cnt", frame_err_cnt, 4'hF);

    // Randomized traffic, mostly well formed.
    do_reset();
    g_pos = 0;
    for (int i = 0; i < 3000; i++) begin
      r   = int'($urandom % 40);
      ch  = (r == 0) ? int'($urandom % NUM_CH) : g_pos;
      sop = (ch == 0);
      if (r == 1) sop = !sop;
      eop = (ch == NUM_CH - 1);
      if (r == 2) eop = !eop;
      in_channel = CH_W'(ch); in_startofpacket = sop; in_endofpacket = eop;
      in_error = (($urandom % 16) == 0) ? 2'($urandom % 4) : 2'b00;
      in_data  = DATA_W'($urandom);
      in_valid = (($urandom % 5) != 0);
      out_ready = (($urandom % 3) != 0);
      tick();
      if (m_accepted) g_pos = (g_pos + 1) % NUM_CH;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
